// File: rtl/median_collector.sv
// median_collector: warms up after start, captures filter medians into a FWFT FIFO, then drains.
// Optional MEDIAN_COLLECT_MINMAX_EN adds min_med/max_med statistics over the accepted captures.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
`ifndef LOG_WMAX
`define LOG_WMAX 4
`endif

module median_collector #(
  parameter int DEPTH       = 16,
  parameter int LATENCY     = 2,
  parameter int CAPTURE_LEN = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [`LOG_WMAX-1:0]    W,
  input  logic [`DATA_LENGTH-1:0] median,
  output logic [`DATA_LENGTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7:0]              captured
`ifdef MEDIAN_COLLECT_MINMAX_EN
  ,
  output logic [`DATA_LENGTH-1:0] min_med,
  output logic [`DATA_LENGTH-1:0] max_med
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = `DATA_LENGTH;
  localparam int SW = 16;
  localparam logic [7:0] LAST = 8'(CAPTURE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [SW-1:0] skip;
  logic [SW-1:0] weff;
  logic [7:0]    attempts;
  logic [AW:0]   wp, rp;
  logic [DW-1:0] mem [DEPTH];
  logic          empty, full;
  logic          wr, rd, push;

  always_comb begin
    weff = (W == '0) ? SW'(1) : SW'(W);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    wr       = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nx = WARMUP;
      WARMUP:  if (skip <= SW'(1)) state_nx = CAPTURE;
      CAPTURE: begin
        wr = 1'b1;
        if (attempts == LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        if (empty) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  always_comb begin
    empty     = (wp == rp);
    full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    out_valid = !empty;
    rd        = out_valid && out_ready;
    push      = wr && (!full || rd);
    out_data  = empty ? '0 : mem[rp[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (rd)   rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= median;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skip     <= '0;
      attempts <= '0;
      captured <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        skip     <= weff + SW'(LATENCY) - SW'(1);
        attempts <= '0;
        captured <= '0;
        overflow <= 1'b0;
      end
      if (state == WARMUP && skip != '0) skip <= skip - SW'(1);
      if (wr) begin
        attempts <= attempts + 8'd1;
        if (push) captured <= captured + 8'd1;
        else      overflow <= 1'b1;
      end
    end
  end

`ifdef MEDIAN_COLLECT_MINMAX_EN
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      min_med <= '1;
      max_med <= '0;
    end else if (push) begin
      if (median < min_med) min_med <= median;
      if (median > max_med) max_med <= median;
    end
  end
`endif

endmodule

// File: tb/tb_median_collector.sv
// tb_median_collector: randomized runs against a cycle-level queue model with a decoupled scoreboard.
// Build with +define+MEDIAN_COLLECT_MINMAX_EN to also check min_med/max_med.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
`ifndef LOG_WMAX
`define LOG_WMAX 4
`endif

module tb_median_collector;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int CAP   = 32;
  localparam int DW    = `DATA_LENGTH;
  localparam int WW    = `LOG_WMAX;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [WW-1:0] W;
  logic [DW-1:0] median, out_data;
  logic          out_valid, busy, done, overflow;
  logic [7:0]    captured;
`ifdef MEDIAN_COLLECT_MINMAX_EN
  logic [DW-1:0] min_med, max_med;
`endif

  median_collector #(
    .DEPTH(DEPTH),
    .LATENCY(LAT),
    .CAPTURE_LEN(CAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .W(W),
    .median(median),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .captured(captured)
`ifdef MEDIAN_COLLECT_MINMAX_EN
    ,
    .min_med(min_med),
    .max_med(max_med)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  // reference model state
  bit run_on = 0;
  int t0 = 0, warm = 1, occ = 0, m_cap = 0;
  bit m_ovf = 0;
  int m_min = (1 << DW) - 1, m_max = 0;
  bit rst_prev = 0;
  logic [DW-1:0] exp_q[$];

  // expected outputs for the current cycle
  bit e_busy, e_valid, e_done, e_ovf, e_rst;
  int e_cap, e_min, e_max;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit rdy,
                      input logic [WW-1:0] w, input logic [DW-1:0] med);
    bit pop, att;
    int rel;
    reset = rst; start = st; out_ready = rdy; W = w; median = med;
    e_rst   = rst_prev;
    rst_prev = rst;
    e_busy  = run_on;
    e_valid = (occ > 0);
    e_cap   = m_cap;
    e_ovf   = m_ovf;
    e_min   = m_min;
    e_max   = m_max;
    rel     = cyc - t0;
    e_done  = run_on && (rel > warm + CAP) && (occ == 0);
    pop     = (occ > 0) && rdy;
    if (rst) begin
      run_on = 0; occ = 0; m_cap = 0; m_ovf = 0;
      m_min = (1 << DW) - 1; m_max = 0;
      exp_q.delete();
    end else begin
      att = run_on && (rel >= warm + 1) && (rel <= warm + CAP);
      if (att) begin
        if (occ < DEPTH || pop) begin
          exp_q.push_back(med);
          occ++;
          m_cap++;
          if (int'(med) < m_min) m_min = int'(med);
          if (int'(med) > m_max) m_max = int'(med);
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) occ--;
      if (e_done) begin
        run_on = 0;
      end else if (st && !run_on) begin
        run_on = 1;
        t0 = cyc;
        warm = ((w == 0) ? 1 : int'(w)) + LAT - 1;
        if (warm < 1) warm = 1;
        m_cap = 0; m_ovf = 0;
        m_min = (1 << DW) - 1; m_max = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("done", 32'(done), 32'(e_done));
      chk("captured", 32'(captured), 32'(e_cap));
      chk("overflow", 32'(overflow), 32'(e_ovf));
`ifdef MEDIAN_COLLECT_MINMAX_EN
      chk("min_med", 32'(min_med), 32'(e_min));
      chk("max_med", 32'(max_med), 32'(e_max));
`endif
      if (e_rst) chk("out_data_after_reset", 32'(out_data), 32'(0));
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("scoreboard_nonempty", 32'(exp_q.size()), 32'(1));
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // mode 0: always ready ramp, 1: stalled during capture, 2: fill then toggle ready,
  // 3: fully random, 4: fixed min/max sequence
  task automatic run(input int mode, input int w, input int base);
    int n = 0;
    int k;
    bit r, s;
    int p;
    int mm[5] = '{64, 62, 76, 121, 48};
    logic [DW-1:0] med;
    p = $urandom_range(1, 4);
    step(0, 1, (mode == 0 || mode == 4), WW'(w), DW'(base));
    while (run_on && n < 2000) begin
      k = cyc - t0 - warm - 1;
      s = 0;
      r = 1;
      med = DW'(base + k);
      case (mode)
        1: r = (k >= CAP);
        2: r = (k < DEPTH) ? 1'b0 : ((cyc % 2) == 0);
        3: begin
          r   = ($urandom_range(0, 3) < p);
          med = DW'($urandom);
          s   = ($urandom_range(0, 7) == 0);
        end
        4: med = (k >= 0 && k < 5) ? DW'(mm[k]) : DW'(64);
        default: r = 1;
      endcase
      step(0, s, r, WW'($urandom), med);
      n++;
    end
    chk("run_end", 32'(run_on), 32'(0));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    reset = 1; start = 0; out_ready = 0; W = '0; median = '0;
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    chk_en = 1;
    step(0, 0, 1, '0, '0);
    run(0, 5, 100);
    run(1, 5, 10);
    run(2, 3, 200);
    // abort a run with reset at its 12th cycle, then restart immediately
    step(0, 1, 0, WW'(5), '0);
    for (int i = 1; i < 12; i++) step(0, 0, 0, WW'($urandom), DW'(i * 7));
    step(1, 0, 1, '0, '0);
    run(0, 0, 40);
    run(4, 5, 0);
    for (int i = 0; i < 8; i++) run(3, $urandom_range(0, (1 << WW) - 1), 0);
    step(0, 0, 1, '0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
